// File: rtl/mem_port_pkg.sv
// Shared defaults, index-width helper and FSM state encoding for the
// memory-port streamer.
package mem_port_pkg;

    localparam int DEF_NUM_WORDS = 10;
    localparam int DEF_WORD_W    = 32;

    // An index needs at least one bit even for a degenerate word count.
    function automatic int idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/mem_port_storage.sv
// Word register array: all words are loaded in parallel on wr_en, and one
// word is read combinationally by index.
module mem_port_storage #(
    parameter int NUM_WORDS = 10,
    parameter int WORD_W    = 32,
    parameter int IDX_W     = 4
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [NUM_WORDS*WORD_W-1:0] wr_data,
    input  logic [IDX_W-1:0]            rd_idx,
    output logic [WORD_W-1:0]           rd_data
);

    logic [WORD_W-1:0] word_arr [NUM_WORDS];

    // Contents carry no reset; they are only meaningful after a capture.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        logic [WORD_W-1:0] word_reg;

        always_ff @(posedge clk) begin
            if (wr_en) begin
                word_reg <= wr_data[gi*WORD_W +: WORD_W];
            end
        end

        assign word_arr[gi] = word_reg;
    end

    // Indices beyond the array (non power-of-two sizes) read as zero.
    assign rd_data = (int'(rd_idx) < NUM_WORDS) ? word_arr[rd_idx] : '0;

endmodule

// File: rtl/mem_port_streamer.sv
// Captures a packed word array on start and streams it out one word per
// accepted handshake, keeping a wrapping running sum of the burst.
module mem_port_streamer
    import mem_port_pkg::*;
#(
    parameter  int NUM_WORDS = DEF_NUM_WORDS,
    parameter  int WORD_W    = DEF_WORD_W,
    localparam int IDX_W     = idx_width(NUM_WORDS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_WORDS*WORD_W-1:0] arr_in,
    input  logic                        start,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WORD_W-1:0]           out_data,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_last,
    output logic [WORD_W-1:0]           sum,
    output logic                        done
);

    state_t            state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [WORD_W-1:0] sum_reg, sum_next;
    logic [WORD_W-1:0] rd_data;
    logic              capture;
    logic              is_last;
    logic              xfer;

    mem_port_storage #(
        .NUM_WORDS (NUM_WORDS),
        .WORD_W    (WORD_W),
        .IDX_W     (IDX_W)
    ) u_storage (
        .clk     (clk),
        .wr_en   (capture),
        .wr_data (arr_in),
        .rd_idx  (idx_reg),
        .rd_data (rd_data)
    );

    assign is_last = (idx_reg == IDX_W'(NUM_WORDS - 1));
    assign xfer    = (state_reg == STREAM) && out_ready;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        sum_next   = sum_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    capture    = 1'b1;
                    idx_next   = '0;
                    sum_next   = '0;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (xfer) begin
                    sum_next = sum_reg + rd_data;
                    // The index parks on the last word rather than wrapping.
                    if (is_last) begin
                        state_next = FINISH;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            sum_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            sum_reg   <= sum_next;
        end
    end

    assign out_valid = (state_reg == STREAM);
    assign busy      = out_valid;
    assign out_last  = out_valid && is_last;
    assign out_data  = out_valid ? rd_data : '0;
    assign out_idx   = idx_reg;
    assign sum       = sum_reg;
    assign done      = (state_reg == FINISH);

endmodule

// File: tb/tb_mem_port_streamer.sv
// Randomized scoreboard bench for mem_port_streamer: stimulus queues the
// expected word stream, a negedge monitor checks every presented word.
module tb_mem_port_streamer;

    localparam int NW = 10;
    localparam int W  = 32;
    localparam int IW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NW*W-1:0]   arr_in;
    logic              start;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      out_data;
    logic [IW-1:0]     out_idx;
    logic              out_last;
    logic [W-1:0]      sum;
    logic              done;

    typedef struct {
        logic [W-1:0] data;
        int           idx;
        bit           last;
        logic [W-1:0] sum;
    } item_t;

    item_t        exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W-1:0] cur_words [NW];
    logic [W-1:0] exp_final;
    int           last_cycles;

    mem_port_streamer #(.NUM_WORDS(NW), .WORD_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .arr_in    (arr_in),
        .start     (start),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .sum       (sum),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented word against the queue head and
    // pops it on a handshake; done must follow the last transfer exactly.
    initial begin
        bit    done_pending;
        item_t e;
        done_pending = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_pending = 1'b0;
            end else begin
                chk("done", done, done_pending);
                done_pending = 1'b0;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_word: got idx %0d data 0x%0h, expected no word", out_idx, out_data);
                    end else begin
                        e = exp_q[0];
                        chk("out_data", out_data, e.data);
                        chk("out_idx", out_idx, e.idx);
                        chk("out_last", out_last, e.last);
                        chk("sum_run", sum, e.sum);
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            done_pending = e.last;
                            $display("xfer idx=%0d data=0x%08h sum_before=0x%08h last=%0d", e.idx, e.data, e.sum, e.last);
                        end
                    end
                end else begin
                    chk("idle_data_zero", out_data, 0);
                    chk("idle_last_zero", out_last, 0);
                end
            end
        end
    end

    // Called at posedge+1 in IDLE; the capture edge follows.
    task automatic launch(input logic [NW*W-1:0] words);
        logic [W-1:0] acc;
        acc = '0;
        arr_in = words;
        start  = 1'b1;
        for (int i = 0; i < NW; i++) begin
            cur_words[i] = words[i*W +: W];
            exp_q.push_back('{data: words[i*W +: W], idx: i, last: (i == NW - 1), sum: acc});
            acc += words[i*W +: W];
        end
        exp_final = acc;
        @(posedge clk); #1;
        start = 1'b0;
        chk("latency_valid", out_valid, 1);
        chk("latency_busy", busy, 1);
        chk("start_idx", out_idx, 0);
        chk("start_sum", sum, 0);
    endtask

    // Drives out_ready until done appears; returns in the FINISH cycle.
    task automatic stream(input int stall_pct, input int poke_idx, input int stall_idx);
        int           n;
        int           stalls;
        bit           poked;
        logic [W-1:0] part;
        n = 0;
        stalls = 0;
        poked = 1'b0;
        while (done !== 1'b1 && n < 1000) begin
            chk("busy_stream", busy, 1);
            start = 1'b0;
            out_ready = (stall_pct > 0) ? ($urandom_range(99) >= stall_pct) : 1'b1;
            if (int'(out_idx) == stall_idx && stalls < 3) begin
                out_ready = 1'b0;
                stalls++;
                part = '0;
                for (int i = 0; i < stall_idx; i++) part += cur_words[i];
                chk("stall_sum", sum, part);
                chk("stall_data", out_data, cur_words[stall_idx]);
            end
            if (!poked && poke_idx >= 0 && int'(out_idx) == poke_idx) begin
                start  = 1'b1;
                arr_in = '1;
                poked  = 1'b1;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        if (n >= 1000) begin
            n_checks++;
            n_fail++;
            $display("FAIL burst_timeout: got no done after %0d cycles, expected done", n);
        end
        last_cycles = n;
        chk("finish_busy", busy, 0);
        chk("finish_valid", out_valid, 0);
        chk("final_sum", sum, exp_final);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("sum_hold_idle", sum, exp_final);
        chk("idle_valid", out_valid, 0);
    endtask

    initial begin
        logic [NW*W-1:0] seq_words;
        logic [NW*W-1:0] rnd_words;
        int              n;

        for (int i = 0; i < NW; i++) seq_words[i*W +: W] = W'(i);

        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        arr_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", out_last, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_sum", sum, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full-throughput burst of 0..9.
        launch(seq_words);
        stream(0, -1, -1);
        chk("burst_cycles", last_cycles, NW);
        chk("sum_45", sum, 45);
        idle_cycle();

        // Three-cycle stall at index 4.
        launch(seq_words);
        stream(0, -1, 4);
        chk("stall_final_sum", sum, 45);
        idle_cycle();

        // Start pulse mid-burst with arr_in overwritten afterwards.
        launch(seq_words);
        stream(0, 2, -1);
        chk("poke_sum", sum, 45);
        idle_cycle();

        // Reset at index 5 discards the burst.
        launch(seq_words);
        out_ready = 1'b1;
        n = 0;
        while (out_idx !== IW'(5) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        exp_final = '0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_idx", out_idx, 0);
        idle_cycle();
        launch(seq_words);
        stream(0, -1, -1);
        idle_cycle();

        // All-ones words wrap the sum.
        launch('1);
        stream(0, -1, -1);
        chk("wrap_sum", sum, 32'hFFFF_FFF6);

        // Start during FINISH is ignored; the next cycle's start is taken.
        for (int i = 0; i < NW; i++) rnd_words[i*W +: W] = $urandom;
        arr_in = rnd_words;
        start  = 1'b1;
        @(posedge clk); #1;
        chk("finish_start_valid", out_valid, 0);
        chk("finish_start_busy", busy, 0);
        chk("finish_start_sum", sum, 32'hFFFF_FFF6);
        launch(rnd_words);
        stream(0, -1, -1);
        idle_cycle();

        // Randomized bursts with random back-pressure and ignored starts.
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < NW; i++) rnd_words[i*W +: W] = $urandom;
            launch(rnd_words);
            stream($urandom_range(50), $urandom_range(NW), -1);
            idle_cycle();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_streamer.md
MEM_PORT_STREAMER -- requirements
Module: mem_port_streamer

Interface
REQ-001 Parameter NUM_WORDS, default 10, number of words in the captured array; legal range 2..256.
REQ-002 Parameter WORD_W, default 32, width of each word in bits.
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port arr_in, input, NUM_WORDS*WORD_W, packed word array; word i occupies bits [i*WORD_W +: WORD_W], word 0 at the LSBs.
REQ-006 Port start, input, 1, single-cycle request to capture arr_in and begin streaming.
REQ-007 Port busy, output, 1, high from the cycle after an accepted start until the last word transfers.
REQ-008 Port out_valid, output, 1, out_data holds a valid word.
REQ-009 Port out_ready, input, 1, downstream accepts the word.
REQ-010 Port out_data, output, WORD_W, current word.
REQ-011 Port out_idx, output, IDX_W = $clog2(NUM_WORDS), index of the current word.
REQ-012 Port out_last, output, 1, high with out_valid when out_idx == NUM_WORDS-1.
REQ-013 Port sum, output, WORD_W, running modulo-2^WORD_W sum of words transferred in the current burst.
REQ-014 Port done, output, 1, one-cycle pulse in the cycle after the last word transfers.

Function
REQ-015 Three states: IDLE, STREAM, FINISH.
REQ-016 IDLE: start=1 captures all NUM_WORDS words of arr_in into internal storage in that cycle, clears sum and out_idx, and moves to STREAM.
REQ-017 start is ignored in STREAM and FINISH; captured data is not overwritten and the burst is not restarted.
REQ-018 STREAM: out_valid=1, out_data = stored word[out_idx]; first out_valid in the cycle after start (latency 1).
REQ-019 Transfer occurs when out_valid && out_ready; on transfer, sum += out_data (wrap, no carry out) and out_idx increments.
REQ-020 With out_ready low, out_data, out_idx, out_last and sum remain stable; out_valid stays high (no retraction).
REQ-021 A transfer with out_last=1 moves to FINISH; out_idx does not wrap past NUM_WORDS-1.
REQ-022 FINISH lasts exactly one cycle: done=1, out_valid=0, busy=0, then return to IDLE; sum holds the final total until the next accepted start.
REQ-023 A start asserted in the FINISH cycle is ignored; a start in the following IDLE cycle is accepted.
REQ-024 Back-to-back transfers sustain one word per cycle with out_ready held high; a full burst takes NUM_WORDS cycles in STREAM.
REQ-025 Changes on arr_in after capture have no effect on the burst in progress.

Reset
REQ-026 rst=1 at any clock edge, including mid-burst, forces IDLE and discards the burst; no done pulse is issued.
REQ-027 Reset values: out_valid=0, busy=0, done=0, out_last=0, out_idx=0, sum=0, out_data=0.
REQ-028 Stored words need not be reset; out_data is driven to 0 whenever out_valid=0.

Structure
REQ-029 Package mem_port_pkg holds NUM_WORDS/WORD_W defaults, IDX_W derivation, and the state enum (IDLE, STREAM, FINISH).
REQ-030 Storage is one sub-module, mem_port_storage: NUM_WORDS x WORD_W register array, parallel write-all, single combinational read by index.
REQ-031 FSM, index counter and accumulator stay in mem_port_streamer.

Verification
REQ-032 arr_in = words 0..9, start pulse, out_ready=1 -> out_data 0,1,...,9 on 10 consecutive cycles, out_last only on word 9, done on the next cycle, sum=45 (0x2D).
REQ-033 Same burst, out_ready low for 3 cycles at idx 4 -> word 4, idx 4 and sum=6 held stable while stalled, then resume; final sum=45.
REQ-034 Start pulse at idx 2, with arr_in changed to all 0xFFFFFFFF after capture -> original stream is unaffected, no restart, sum=45.
REQ-035 rst asserted at idx 5 -> next cycle out_valid=0, busy=0, sum=0, no done; a new start streams from idx 0.
REQ-036 Words all 0xFFFFFFFF -> sum wraps to 0xFFFFFFF6 after 10 transfers.
REQ-037 Start in the FINISH cycle is ignored; start one cycle later begins a new burst with sum cleared.
